rv32_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the immediate generator's ExtOP select, the ALU controls, the register-file write and the PC update.
- Handshakes with instruction memory and data memory through req/ready pairs. Sits between the instruction register and the shared datapath.

---
 rtl/rv32_ctrl_pkg.sv | 71 +++++++
 rtl/rv32_multicycle_ctrl_if.sv | 35 +++
 rtl/rv32_ctrl_decode.sv | 86 ++++++++
 rtl/rv32_multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, immediate/ALU/mux selects,
// FSM states and instruction classes, plus the branch-condition helper.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  // ALU codes are {funct7[5], funct3} so R-type decode is a direct copy.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_PCIMM  = 2'd1;
  localparam logic [1:0] PC_RS1IMM = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_DMEM = 2'd1;
  localparam logic [1:0] WB_IMM  = 2'd2;

  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_IMM  = 2'd1;
  localparam logic [1:0] BSRC_FOUR = 2'd2;

  localparam logic ASRC_RS1 = 1'b0;
  localparam logic ASRC_PC  = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LUI, CL_BRANCH, CL_LOAD, CL_STORE, CL_JAL, CL_JALR
  } iclass_t;

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic less);
    case (f3)
      3'b000:         return zero;
      3'b001:         return !zero;
      3'b100, 3'b110: return less;
      3'b101, 3'b111: return !less;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave the datapath side.
interface rv32_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        zero;
  logic        less;
  logic        imem_req;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  ExtOP;
  logic        alu_asrc;
  logic [1:0]  alu_bsrc;
  logic [3:0]  alu_ctr;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  mem_op;
  logic        illegal;
  logic [2:0]  state_dbg;

  modport master (
    input  instr, imem_ready, dmem_ready, zero, less,
    output imem_req, ir_we, pc_we, pc_sel, ExtOP, alu_asrc, alu_bsrc, alu_ctr,
           reg_we, wb_sel, dmem_req, dmem_we, mem_op, illegal, state_dbg
  );

  modport slave (
    output instr, imem_ready, dmem_ready, zero, less,
    input  imem_req, ir_we, pc_we, pc_sel, ExtOP, alu_asrc, alu_bsrc, alu_ctr,
           reg_we, wb_sel, dmem_req, dmem_we, mem_op, illegal, state_dbg
  );
endinterface

// File: rtl/rv32_ctrl_decode.sv
// Combinational RV32I decode: instruction fields -> immediate format, ALU controls, writeback select,
// instruction class and legality. Zero latency, no flow control.
module rv32_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] ext_op,
  output logic [3:0] alu_ctr,
  output logic       alu_asrc,
  output logic [1:0] alu_bsrc,
  output logic [1:0] wb_sel,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    ext_op   = EXT_I;
    alu_ctr  = ALU_ADD;
    alu_asrc = ASRC_RS1;
    alu_bsrc = BSRC_RS2;
    wb_sel   = WB_ALU;
    iclass   = CL_ALU;
    legal    = 1'b1;
    case (opcode)
      OPC_OP: begin
        alu_ctr = {funct7[5], funct3};
        legal   = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OPIMM: begin
        alu_bsrc = BSRC_IMM;
        if (funct3 == 3'b001) begin
          alu_ctr = ALU_SLL;
          legal   = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          alu_ctr = {funct7[5], 3'b101};
          legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          // funct7 bits are immediate bits here, so arithmetic shift encoding must not leak in.
          alu_ctr = {1'b0, funct3};
        end
      end
      OPC_LOAD: begin
        alu_bsrc = BSRC_IMM;
        wb_sel   = WB_DMEM;
        iclass   = CL_LOAD;
      end
      OPC_STORE: begin
        ext_op   = EXT_S;
        alu_bsrc = BSRC_IMM;
        iclass   = CL_STORE;
      end
      OPC_BRANCH: begin
        ext_op  = EXT_B;
        alu_ctr = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        iclass  = CL_BRANCH;
      end
      OPC_LUI: begin
        ext_op   = EXT_U;
        alu_bsrc = BSRC_IMM;
        wb_sel   = WB_IMM;
        iclass   = CL_LUI;
      end
      OPC_AUIPC: begin
        ext_op   = EXT_U;
        alu_asrc = ASRC_PC;
        alu_bsrc = BSRC_IMM;
      end
      OPC_JAL: begin
        ext_op   = EXT_J;
        alu_asrc = ASRC_PC;
        alu_bsrc = BSRC_FOUR;
        iclass   = CL_JAL;
      end
      OPC_JALR: begin
        alu_asrc = ASRC_PC;
        alu_bsrc = BSRC_FOUR;
        iclass   = CL_JALR;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// RV32I multi-cycle control FSM; 3 (branch) to 5 (load) cycles per instruction with ready asserted.
// Waits indefinitely in FETCH for imem_ready and in MEM for dmem_ready, holding the request high.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned RESET_STATE_DBG = 0
) (
  input logic                    clk,
  input logic                    rst,
  rv32_multicycle_ctrl_if.master bus
);

  state_t     state, state_nxt;
  logic       illegal_q;
  logic [2:0] funct3;

  logic [2:0] d_ext;
  logic [3:0] d_alu;
  logic       d_asrc;
  logic [1:0] d_bsrc;
  logic [1:0] d_wb;
  iclass_t    d_class;
  logic       d_legal;

  logic       imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we;
  logic [1:0] pc_sel;
  logic       dec_active;
  logic       unused_instr_bits;

  assign funct3            = bus.instr[14:12];
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  rv32_ctrl_decode u_decode (
    .opcode   (bus.instr[6:0]),
    .funct3   (funct3),
    .funct7   (bus.instr[31:25]),
    .ext_op   (d_ext),
    .alu_ctr  (d_alu),
    .alu_asrc (d_asrc),
    .alu_bsrc (d_bsrc),
    .wb_sel   (d_wb),
    .iclass   (d_class),
    .legal    (d_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = d_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (d_class == CL_BRANCH) begin
          pc_we     = 1'b1;
          pc_sel    = branch_taken(funct3, bus.zero, bus.less) ? PC_PCIMM : PC_PLUS4;
          state_nxt = S_FETCH;
        end else if (d_class == CL_LOAD || d_class == CL_STORE) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (d_class == CL_STORE);
        if (bus.dmem_ready) begin
          if (d_class == CL_STORE) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = (d_class == CL_JAL)  ? PC_PCIMM :
                    (d_class == CL_JALR) ? PC_RS1IMM : PC_PLUS4;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    // A reset cycle aborts the instruction: nothing may commit to PC, regfile or memory.
    if (rst) begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  assign dec_active = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);

  assign bus.imem_req  = imem_req;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.pc_sel    = pc_sel;
  assign bus.reg_we    = reg_we;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.ExtOP     = dec_active ? d_ext  : EXT_I;
  assign bus.alu_ctr   = dec_active ? d_alu  : ALU_ADD;
  assign bus.alu_asrc  = dec_active ? d_asrc : ASRC_RS1;
  assign bus.alu_bsrc  = dec_active ? d_bsrc : BSRC_RS2;
  assign bus.wb_sel    = dec_active ? d_wb   : WB_ALU;
  assign bus.mem_op    = dec_active ? funct3 : 3'b000;
  assign bus.illegal   = illegal_q;
  assign bus.state_dbg = (RESET_STATE_DBG != 0) ? state : 3'b000;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: per-instruction strobe timing, decode selects,
// memory wait states, trap stickiness and reset abort.
module tb_rv32_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_multicycle_ctrl_if bus();

  rv32_multicycle_ctrl #(.RESET_STATE_DBG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Per-instruction trace summary, filled by run().
  int         lat, irwe_cyc, pcwe_cyc, pcwe_cnt, regwe_cyc, regwe_cnt, dreq_cnt;
  logic [1:0] pcwe_sel, wbsel_we, bsrc_we;
  logic       asrc_we, dwe_seen, memop_stable, ext_stable;
  logic [2:0] ext_dec, memop_val;
  logic [3:0] alu_dec;

  task automatic run(input logic [31:0] ins, input logic z, input logic l, input int dly);
    int  memcnt;
    bit  done;
    bus.instr      = ins;
    bus.zero       = z;
    bus.less       = l;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    lat = -1; irwe_cyc = -1; pcwe_cyc = -1; pcwe_cnt = 0; regwe_cyc = -1; regwe_cnt = 0;
    dreq_cnt = 0; dwe_seen = 1'b0; memop_stable = 1'b1; ext_stable = 1'b1;
    pcwe_sel = 2'd3; wbsel_we = 2'd3; bsrc_we = 2'd3; asrc_we = 1'b0;
    ext_dec = 3'd7; alu_dec = 4'hF; memop_val = 3'd0;
    memcnt = 0; done = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      bus.dmem_ready = bus.dmem_req && (memcnt == dly - 1);
      #1;
      if (bus.ir_we && irwe_cyc < 0) irwe_cyc = c;
      if (bus.pc_we) begin pcwe_cnt++; pcwe_cyc = c; pcwe_sel = bus.pc_sel; end
      if (bus.reg_we) begin
        regwe_cnt++; regwe_cyc = c;
        wbsel_we = bus.wb_sel; asrc_we = bus.alu_asrc; bsrc_we = bus.alu_bsrc;
      end
      if (bus.dmem_req) begin
        dreq_cnt++;
        if (dreq_cnt == 1) memop_val = bus.mem_op;
        else if (bus.mem_op != memop_val) memop_stable = 1'b0;
        dwe_seen = dwe_seen | bus.dmem_we;
        memcnt++;
      end
      if (c == 2) begin ext_dec = bus.ExtOP; alu_dec = bus.alu_ctr; end
      else if (c > 2 && bus.ExtOP != ext_dec) ext_stable = 1'b0;
      @(posedge clk); #2;
      if (bus.state_dbg == 3'd0) begin lat = c; done = 1; end
    end
    bus.dmem_ready = 1'b0;
  endtask

  int bad;

  initial begin
    bus.instr = 32'h0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    bus.zero = 1'b0; bus.less = 1'b0;

    // Reset state with no instruction available
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; #1;
    chk("rst_state", bus.state_dbg, 3'd0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_strobes", {bus.imem_req, bus.ir_we, bus.pc_we, bus.reg_we, bus.dmem_req, bus.dmem_we}, 6'b100000);
    chk("rst_ctl", {bus.ExtOP, bus.pc_sel, bus.alu_asrc, bus.alu_bsrc, bus.alu_ctr, bus.wb_sel}, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("fetch_wait_state", bus.state_dbg, 3'd0);
    chk("fetch_wait_req", bus.imem_req, 1'b1);

    // ADDI x1,x0,5
    run(32'h00500093, 1'b0, 1'b0, 1);
    chk("addi_irwe_cyc", irwe_cyc, 1);
    chk("addi_ext", ext_dec, 3'b000);
    chk("addi_alu", alu_dec, 4'h0);
    chk("addi_regwe_cyc", regwe_cyc, 4);
    chk("addi_pcwe_cyc", pcwe_cyc, 4);
    chk("addi_pcsel", pcwe_sel, 2'd0);
    chk("addi_wbsel", wbsel_we, 2'd0);
    chk("addi_bsrc", bsrc_we, 2'd1);
    chk("addi_lat", lat, 4);

    // SUB x3,x1,x2 and SRAI x1,x1,1
    run(32'h402081B3, 1'b0, 1'b0, 1);
    chk("sub_alu", alu_dec, 4'h8);
    chk("sub_bsrc", bsrc_we, 2'd0);
    chk("sub_lat", lat, 4);
    run(32'h4010D093, 1'b0, 1'b0, 1);
    chk("srai_alu", alu_dec, 4'hD);
    chk("srai_lat", lat, 4);

    // Branches: BEQ taken, BNE not taken (zero=1), BLT taken, BGEU not taken (less=1)
    run(32'h00000463, 1'b1, 1'b0, 1);
    chk("beq_ext", ext_dec, 3'b011);
    chk("beq_alu", alu_dec, 4'h8);
    chk("beq_pcwe_cyc", pcwe_cyc, 3);
    chk("beq_pcsel", pcwe_sel, 2'd1);
    chk("beq_regwe_cnt", regwe_cnt, 0);
    chk("beq_lat", lat, 3);
    run(32'h00001463, 1'b1, 1'b0, 1);
    chk("bne_pcwe_cyc", pcwe_cyc, 3);
    chk("bne_pcsel", pcwe_sel, 2'd0);
    chk("bne_regwe_cnt", regwe_cnt, 0);
    run(32'h00004463, 1'b0, 1'b1, 1);
    chk("blt_alu", alu_dec, 4'h2);
    chk("blt_pcsel", pcwe_sel, 2'd1);
    run(32'h00007463, 1'b0, 1'b1, 1);
    chk("bgeu_alu", alu_dec, 4'h3);
    chk("bgeu_pcsel", pcwe_sel, 2'd0);

    // LW x5,4(x1) with ready immediately and after 3 request cycles
    run(32'h0040A283, 1'b0, 1'b0, 1);
    chk("lw_fast_lat", lat, 5);
    run(32'h0040A283, 1'b0, 1'b0, 3);
    chk("lw_dreq_cnt", dreq_cnt, 3);
    chk("lw_memop", memop_val, 3'b010);
    chk("lw_memop_stable", memop_stable, 1'b1);
    chk("lw_dwe", dwe_seen, 1'b0);
    chk("lw_regwe_cyc", regwe_cyc, 7);
    chk("lw_wbsel", wbsel_we, 2'd1);
    chk("lw_ext_stable", ext_stable, 1'b1);
    chk("lw_lat", lat, 7);

    // SW x2,8(x1)
    run(32'h0020A423, 1'b0, 1'b0, 1);
    chk("sw_ext", ext_dec, 3'b010);
    chk("sw_dwe", dwe_seen, 1'b1);
    chk("sw_regwe_cnt", regwe_cnt, 0);
    chk("sw_pcwe_cyc", pcwe_cyc, 4);
    chk("sw_pcsel", pcwe_sel, 2'd0);
    chk("sw_lat", lat, 4);

    // JAL x1,+16 / JALR x1,0(x2) / LUI x1,0x12345
    run(32'h010000EF, 1'b0, 1'b0, 1);
    chk("jal_ext", ext_dec, 3'b100);
    chk("jal_wb", {regwe_cyc[3:0], pcwe_sel, asrc_we, bsrc_we, wbsel_we}, {4'd4, 2'd1, 1'b1, 2'd2, 2'd0});
    run(32'h000100E7, 1'b0, 1'b0, 1);
    chk("jalr_ext", ext_dec, 3'b000);
    chk("jalr_wb", {regwe_cyc[3:0], pcwe_sel, asrc_we, bsrc_we, wbsel_we}, {4'd4, 2'd2, 1'b1, 2'd2, 2'd0});
    run(32'h123450B7, 1'b0, 1'b0, 1);
    chk("lui_ext", ext_dec, 3'b001);
    chk("lui_wbsel", wbsel_we, 2'd2);
    chk("lui_lat", lat, 4);

    // MUL encoding is outside RV32I
    run(32'h022081B3, 1'b0, 1'b0, 1);
    chk("mul_trap_state", bus.state_dbg, 3'd5);
    chk("mul_illegal", bus.illegal, 1'b1);

    // Unknown opcode: trap, sticky illegal, then reset recovers
    bus.instr = 32'h0000007F; bus.imem_ready = 1'b1;
    rst = 1'b1; @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #3;
    chk("trap_dec_state", bus.state_dbg, 3'd1);
    chk("trap_dec_illegal", bus.illegal, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #3;
      if (bus.state_dbg != 3'd5 || bus.illegal != 1'b1 ||
          {bus.imem_req, bus.ir_we, bus.pc_we, bus.reg_we, bus.dmem_req, bus.dmem_we} != 6'b0)
        bad++;
    end
    chk("trap_hold_bad_cycles", bad, 0);
    rst = 1'b1; bus.imem_ready = 1'b0;
    @(posedge clk); #2; rst = 1'b0; #1;
    chk("trap_rst_state", bus.state_dbg, 3'd0);
    chk("trap_rst_illegal", bus.illegal, 1'b0);

    // Reset while MEM is waiting on dmem_ready
    bus.instr = 32'h0040A283; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
    rst = 1'b1; @(posedge clk); #2; rst = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("memrst_pre", {bus.state_dbg, bus.dmem_req}, {3'd3, 1'b1});
    rst = 1'b1; #1;
    chk("memrst_cycle_we", {bus.pc_we, bus.reg_we}, 2'b00);
    @(posedge clk); #2; rst = 1'b0; bus.imem_ready = 1'b0; #1;
    chk("memrst_state", bus.state_dbg, 3'd0);
    chk("memrst_after", {bus.dmem_req, bus.pc_we, bus.reg_we}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
